// File: rtl/spi_display_regfile_if.sv
// SPI pin bundle between the SoC SPI master and the display register file.
interface spi_display_regfile_if;
   logic spi_sclk_i;
   logic spi_ss_i;
   logic spi_mosi_i;
   logic spi_miso_o;

   modport slave  (input spi_sclk_i, spi_ss_i, spi_mosi_i, output spi_miso_o);
   modport master (output spi_sclk_i, spi_ss_i, spi_mosi_i, input spi_miso_o);
endinterface

// File: rtl/spi_display_regfile.sv
// SPI-slave register file feeding an N-digit seven-segment display.
// SPI pins are oversampled in block_clk_i.
// Frames are 16 bits: cmd[15:12] addr[11:8] data[7:0].
// Register map: 0 = enable, 1..NUM_DIGITS = digits, NUM_DIGITS+1 = radix.
module spi_display_regfile #(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned SHADOW_EN    = 0,
   parameter logic [7:0]  RESET_ENABLE = 8'h00
) (
   input  logic                    block_clk_i,
   input  logic                    rst_low_i,
   spi_display_regfile_if.slave    spi,
   output logic [4*NUM_DIGITS-1:0] digit_value_o,
   output logic [NUM_DIGITS-1:0]   digit_enable_o,
   output logic [NUM_DIGITS-1:0]   digit_radix_o,
   output logic                    frame_error_o
);
   localparam int unsigned NUM_REGS = NUM_DIGITS + 2;

   typedef enum logic [3:0] {
      CMD_WRITE  = 4'h1,
      CMD_READ   = 4'h2,
      CMD_CLEAR  = 4'h3,
      CMD_COMMIT = 4'h4
   } cmd_e;

   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic       sclk_s, ss_s, mosi_s;
   logic       sclk_prev_q, ss_prev_q;
   logic       armed_q, armed_d;
   logic [4:0] cnt_q, cnt_d;
   logic [14:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic       ovf_q, ovf_d;
   logic       err_q, err_d;
   logic [7:0] wbank_q [NUM_REGS];
   logic [7:0] wbank_d [NUM_REGS];
   logic [7:0] act     [NUM_REGS];

   logic        rise, fall, ss_rise, exec, hdr_done;
   logic [15:0] frame;
   logic [3:0]  hdr_cmd, hdr_addr;
   logic [7:0]  rd_data;

   // Pin synchronisers; ss resets to "selected" so a frame already in flight
   // at reset release is ignored until ss is seen high (see armed_q).
   always_ff @(posedge block_clk_i or negedge rst_low_i) begin
      if (!rst_low_i) begin
         sclk_sync_q <= '1;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.spi_sclk_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   spi.spi_ss_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi_i};
      end
   end

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s   = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Edge events, frame decode and read-back data selection
   always_comb begin
      rise     = armed_q & ~ss_s & sclk_s & ~sclk_prev_q;
      fall     = armed_q & ~ss_s & ~sclk_s & sclk_prev_q;
      ss_rise  = ss_s & ~ss_prev_q;
      frame    = {rx_q, mosi_s};
      exec     = rise && (cnt_q == 5'd15);
      hdr_done = rise && (cnt_q == 5'd7);
      hdr_cmd  = rx_q[6:3];
      hdr_addr = {rx_q[2:0], mosi_s};
      rd_data  = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (32'(hdr_addr) == k) rd_data = wbank_q[k];
      end
   end

   // Next-state for counter, shifters, error pulse and the written bank
   always_comb begin
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      ovf_d   = ovf_q;
      err_d   = 1'b0;
      armed_d = armed_q | ss_s;
      wbank_d = wbank_q;
      if (ss_rise) begin
         cnt_d = '0;
         tx_d  = '1;
         ovf_d = 1'b0;
         err_d = ovf_q || ((cnt_q != 5'd0) && (cnt_q != 5'd16));
      end else if (rise) begin
         if (cnt_q == 5'd16) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 5'd1;
            rx_d  = frame[14:0];
         end
         if (hdr_done && (hdr_cmd == CMD_READ)) tx_d = rd_data;
      end else if (fall && (cnt_q >= 5'd9) && (cnt_q <= 5'd15)) begin
         tx_d = {tx_q[6:0], 1'b1};
      end
      if (exec) begin
         if (frame[15:12] == CMD_WRITE) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
               if (32'(frame[11:8]) == k) wbank_d[k] = frame[7:0];
            end
         end else if (frame[15:12] == CMD_CLEAR) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) wbank_d[k] = '0;
         end
      end
   end

   // Frame state and written-bank registers
   always_ff @(posedge block_clk_i or negedge rst_low_i) begin
      if (!rst_low_i) begin
         sclk_prev_q <= 1'b1;
         ss_prev_q   <= 1'b0;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '1;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         for (int unsigned k = 0; k < NUM_REGS; k++) wbank_q[k] <= '0;
         wbank_q[0]  <= RESET_ENABLE;
      end else begin
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         wbank_q     <= wbank_d;
      end
   end

   // With shadowing the written bank is the shadow and a separate active
   // bank is loaded on COMMIT; otherwise the written bank drives the outputs.
   if (SHADOW_EN != 0) begin : g_shadow
      logic [7:0] act_q [NUM_REGS];
      logic       commit;
      assign commit = exec && (frame[15:12] == CMD_COMMIT);

      // Active bank copies the shadow bank on COMMIT
      always_ff @(posedge block_clk_i or negedge rst_low_i) begin
         if (!rst_low_i) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) act_q[k] <= '0;
            act_q[0] <= RESET_ENABLE;
         end else if (commit) begin
            act_q <= wbank_q;
         end
      end
      assign act = act_q;
   end else begin : g_direct
      assign act = wbank_q;
   end

   // Display outputs from the active bank
   always_comb begin
      digit_value_o = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         digit_value_o[4*k +: 4] = act[k+1][3:0];
      end
      digit_enable_o = act[0][NUM_DIGITS-1:0];
      digit_radix_o  = act[NUM_REGS-1][NUM_DIGITS-1:0];
   end

   assign frame_error_o  = err_q;
   assign spi.spi_miso_o = ss_s | tx_q[7];
endmodule

// File: tb/tb_spi_display_regfile.sv
// Bench for spi_display_regfile: one direct-write instance (A) and one
// shadow/commit instance (B) share the same SPI stimulus.
module tb_spi_display_regfile;
   localparam int unsigned HALF = 6;
   localparam int unsigned GAP  = 8;

   logic clk = 1'b0;
   logic rst_n, sclk, ss, mosi;
   always #5 clk = ~clk;

   spi_display_regfile_if ifA ();
   spi_display_regfile_if ifB ();
   assign ifA.spi_sclk_i = sclk;
   assign ifA.spi_ss_i   = ss;
   assign ifA.spi_mosi_i = mosi;
   assign ifB.spi_sclk_i = sclk;
   assign ifB.spi_ss_i   = ss;
   assign ifB.spi_mosi_i = mosi;

   logic [31:0] valA, valB;
   logic [7:0]  enA, enB, radA, radB;
   logic        errA, errB;

   spi_display_regfile #(.NUM_DIGITS(8), .SYNC_STAGES(2), .SHADOW_EN(0), .RESET_ENABLE(8'h3C)) dutA (
      .block_clk_i(clk), .rst_low_i(rst_n), .spi(ifA),
      .digit_value_o(valA), .digit_enable_o(enA), .digit_radix_o(radA), .frame_error_o(errA));

   spi_display_regfile #(.NUM_DIGITS(8), .SYNC_STAGES(2), .SHADOW_EN(1), .RESET_ENABLE(8'h00)) dutB (
      .block_clk_i(clk), .rst_low_i(rst_n), .spi(ifB),
      .digit_value_o(valB), .digit_enable_o(enB), .digit_radix_o(radB), .frame_error_o(errB));

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned ecA = 0, ecB = 0;

   // Count cycles with frame_error_o high
   always @(posedge clk) begin
      if (errA === 1'b1) ecA <= ecA + 1;
      if (errB === 1'b1) ecB <= ecB + 1;
   end

   typedef struct {
      logic [15:0] w;
      int unsigned nbits;
      logic [31:0] valA;
      logic [7:0]  enA, radA;
      logic [31:0] valB;
      logic [7:0]  enB, radB;
      logic [7:0]  rdA, rdB;
      int unsigned err;
   } vec_t;

   vec_t vq[$];
   logic [7:0] sbA[$], sbB[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add(input logic [15:0] w, input int unsigned nb,
                      input logic [31:0] vA, input logic [7:0] eA, input logic [7:0] rA,
                      input logic [31:0] vB, input logic [7:0] eB, input logic [7:0] rB,
                      input logic [7:0] dA, input logic [7:0] dB, input int unsigned er);
      vec_t v;
      v.w = w; v.nbits = nb;
      v.valA = vA; v.enA = eA; v.radA = rA;
      v.valB = vB; v.enB = eB; v.radB = rB;
      v.rdA = dA; v.rdB = dB; v.err = er;
      vq.push_back(v);
   endtask

   // Drive nbits of a frame; bits past 16 send 0. MISO is sampled just before
   // rises 9..16. With hold_last the final rise is left to the caller.
   task automatic send(input logic [15:0] w, input int unsigned nbits, input bit hold_last,
                       output logic [7:0] rA, output logic [7:0] rB);
      rA = '1;
      rB = '1;
      @(negedge clk);
      ss = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int unsigned i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         mosi = (i < 16) ? w[15-i] : 1'b0;
         repeat (HALF) @(negedge clk);
         if (i >= 8 && i < 16) begin
            rA = {rA[6:0], ifA.spi_miso_o};
            rB = {rB[6:0], ifB.spi_miso_o};
         end
         if (!(hold_last && (i == nbits - 1))) begin
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
         end
      end
   endtask

   task automatic end_frame();
      @(negedge clk);
      ss   = 1'b1;
      mosi = 1'b0;
      repeat (GAP) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      logic [7:0] rA, rB;
      int unsigned e0A, e0B;

      //   w        nb  valA          enA    radA   valB          enB    radB   rdA    rdB   err
      add(16'h2300, 16, 32'h00000500, 8'h3C, 8'h00, 32'h00000000, 8'h00, 8'h00, 8'hA5, 8'hA5, 0);
      add(16'h10FF, 16, 32'h00000500, 8'hFF, 8'h00, 32'h00000000, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h1981, 16, 32'h00000500, 8'hFF, 8'h81, 32'h00000000, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h2900, 16, 32'h00000500, 8'hFF, 8'h81, 32'h00000000, 8'h00, 8'h00, 8'h81, 8'h81, 0);
      add(16'h4000, 16, 32'h00000500, 8'hFF, 8'h81, 32'h00000500, 8'hFF, 8'h81, 8'hFF, 8'hFF, 0);
      add(16'h3000, 16, 32'h00000000, 8'h00, 8'h00, 32'h00000500, 8'hFF, 8'h81, 8'hFF, 8'hFF, 0);
      add(16'h1107, 16, 32'h00000007, 8'h00, 8'h00, 32'h00000500, 8'hFF, 8'h81, 8'hFF, 8'hFF, 0);
      add(16'h2100, 16, 32'h00000007, 8'h00, 8'h00, 32'h00000500, 8'hFF, 8'h81, 8'h07, 8'h07, 0);
      add(16'h4000, 16, 32'h00000007, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h1288, 11, 32'h00000007, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'hFF, 8'hFF, 1);
      add(16'h1288, 16, 32'h00000087, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h1C55, 16, 32'h00000087, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h2C00, 16, 32'h00000087, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      add(16'h7123, 16, 32'h00000087, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h2200, 16, 32'h00000087, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'h88, 8'h88, 0);
      add(16'h1455, 17, 32'h00005087, 8'h00, 8'h00, 32'h00000007, 8'h00, 8'h00, 8'hFF, 8'hFF, 1);
      add(16'h4000, 16, 32'h00005087, 8'h00, 8'h00, 32'h00005087, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h1803, 16, 32'h30005087, 8'h00, 8'h00, 32'h00005087, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h2800, 16, 32'h30005087, 8'h00, 8'h00, 32'h00005087, 8'h00, 8'h00, 8'h03, 8'h03, 0);
      add(16'h105A, 16, 32'h30005087, 8'h5A, 8'h00, 32'h00005087, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);
      add(16'h2000, 16, 32'h30005087, 8'h5A, 8'h00, 32'h00005087, 8'h00, 8'h00, 8'h5A, 8'h5A, 0);

      sclk  = 1'b1;
      ss    = 1'b1;
      mosi  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (GAP) @(negedge clk);

      // Reset state
      check("rst valA", valA, 32'h0);
      check("rst enA", enA, 8'h3C);
      check("rst radA", radA, 8'h00);
      check("rst enB", enB, 8'h00);
      check("rst misoA", ifA.spi_miso_o, 1'b1);
      check("rst errcnt", ecA + ecB, 0);

      // Write latency: digit 3 appears exactly one cycle after the 16th rise event
      e0A = ecA;
      send(16'h13A5, 16, 1'b1, rA, rB);
      @(negedge clk);
      sclk = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 check("lat A before", valA[11:8], 4'h0);
      @(posedge clk);
      #1 check("lat A after", valA[11:8], 4'h5);
      check("lat B shadow", valB[11:8], 4'h0);
      repeat (HALF) @(negedge clk);
      end_frame();
      check("lat errA", ecA - e0A, 0);

      // Table-driven frames; MISO bytes go through the scoreboard
      for (int i = 0; i < vq.size(); i++) begin
         v   = vq[i];
         e0A = ecA;
         e0B = ecB;
         if (v.nbits >= 16) begin
            sbA.push_back(v.rdA);
            sbB.push_back(v.rdB);
         end
         send(v.w, v.nbits, 1'b0, rA, rB);
         end_frame();
         if (v.nbits >= 16) begin
            check($sformatf("v%0d misoA", i), rA, sbA.pop_front());
            check($sformatf("v%0d misoB", i), rB, sbB.pop_front());
         end
         check($sformatf("v%0d valA", i), valA, v.valA);
         check($sformatf("v%0d enA", i), enA, v.enA);
         check($sformatf("v%0d radA", i), radA, v.radA);
         check($sformatf("v%0d valB", i), valB, v.valB);
         check($sformatf("v%0d enB", i), enB, v.enB);
         check($sformatf("v%0d radB", i), radB, v.radB);
         check($sformatf("v%0d errA", i), ecA - e0A, v.err);
         check($sformatf("v%0d errB", i), ecB - e0B, v.err);
      end

      // Reset in the middle of a WRITE frame
      send(16'h1666, 12, 1'b0, rA, rB);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst valA", valA, 32'h0);
      check("midrst enA", enA, 8'h3C);
      check("midrst valB", valB, 32'h0);
      check("midrst misoB", ifB.spi_miso_o, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      e0A = ecA;
      // Leftover clocks with ss still low must be ignored
      for (int j = 0; j < 4; j++) begin
         sclk = 1'b0;
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      end_frame();
      check("midrst no err", ecA - e0A, 0);
      check("midrst val kept", valA, 32'h0);

      send(16'h1666, 16, 1'b0, rA, rB);
      end_frame();
      check("post valA", valA, 32'h00600000);
      check("post enA", enA, 8'h3C);
      check("post valB", valB, 32'h0);
      send(16'h4000, 16, 1'b0, rA, rB);
      end_frame();
      check("post commit valB", valB, 32'h00600000);
      check("post commit enB", enB, 8'h00);
      check("post errA", ecA - e0A, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
